time_of_day_counter: RTL and testbench

Time-of-day keeper that sits directly downstream of the system clock divider. It samples the divider's 1 s square wave in the `sys_clk` domain and turns each rising edge into a single-cycle tick. It maintains an HH:MM:SS count in packed BCD, with 24-hour wrap, synchronous time load and a one-shot alarm. Its outputs feed the display scan and alarm logic.

---
 rtl/time_of_day_counter_pkg.sv | 33 +++
 rtl/time_of_day_counter_if.sv | 30 +++
 rtl/time_of_day_counter_bcd_mod_counter.sv | 57 +++++
 rtl/time_of_day_counter.sv | 144 ++++++++++++++
 tb/tb_time_of_day_counter.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/time_of_day_counter_pkg.sv
// Shared definitions for the time-of-day counter.
//   - Digit, pair and time widths, and the BCD digit and hour limits.
//   - bcd_time_t: packed {hh, mm, ss}, two BCD digits per field.
//   - bcd_time_valid(): 1 when every digit is a decimal digit and the
//     value is a legal time of day (00:00:00 .. 23:59:59).
package time_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_PAIR_W  = 2 * BCD_DIGIT_W;
  localparam int TIME_W      = 24;

  localparam logic [BCD_DIGIT_W-1:0] DIGIT_MAX = 4'd9;
  localparam logic [BCD_DIGIT_W-1:0] TENS_MAX  = 4'd5;
  localparam logic [BCD_PAIR_W-1:0]  HOUR_MAX  = 8'd23;

  typedef struct packed {
    logic [BCD_PAIR_W-1:0] hh;
    logic [BCD_PAIR_W-1:0] mm;
    logic [BCD_PAIR_W-1:0] ss;
  } bcd_time_t;

  function automatic logic bcd_time_valid(input bcd_time_t t);
    logic [BCD_PAIR_W-1:0] hours;
    // Binary hour value.  The worst case for two raw nibbles is
    // 15*10 + 15 = 165, which still fits in 8 bits.
    hours = {4'd0, t.hh[7:4]} * 8'd10 + {4'd0, t.hh[3:0]};
    return (t.hh[7:4] <= DIGIT_MAX) && (t.hh[3:0] <= DIGIT_MAX) &&
           (t.mm[7:4] <= TENS_MAX)  && (t.mm[3:0] <= DIGIT_MAX) &&
           (t.ss[7:4] <= TENS_MAX)  && (t.ss[3:0] <= DIGIT_MAX) &&
           (hours <= HOUR_MAX);
  endfunction

endpackage

// File: rtl/time_of_day_counter_if.sv
// Bus between the time-of-day counter and its user (the divider, the
// display scan and the alarm logic).
//   master : drives clk_1s, run, set_valid/set_time, alarm_wr/alarm_time;
//            receives time_bcd, sec_tick, day_wrap, alarm, set_err.
//   slave  : the counter itself, with the opposite directions.
interface time_of_day_counter_if;
  import time_pkg::*;

  logic              clk_1s;
  logic              run;
  logic              set_valid;
  logic [TIME_W-1:0] set_time;
  logic              alarm_wr;
  logic [TIME_W-1:0] alarm_time;
  logic [TIME_W-1:0] time_bcd;
  logic              sec_tick;
  logic              day_wrap;
  logic              alarm;
  logic              set_err;

  modport master (
    output clk_1s, run, set_valid, set_time, alarm_wr, alarm_time,
    input  time_bcd, sec_tick, day_wrap, alarm, set_err
  );

  modport slave (
    input  clk_1s, run, set_valid, set_time, alarm_wr, alarm_time,
    output time_bcd, sec_tick, day_wrap, alarm, set_err
  );
endinterface

// File: rtl/time_of_day_counter_bcd_mod_counter.sv
// Two-digit BCD counter that counts 00 .. MODULUS-1.
//   clk, rst_n : clock and asynchronous active-low reset.
//   inc        : advance by one.  Ignored while load is high.
//   load       : take load_val at the next edge.
//   load_val   : packed BCD value to load.
//   count      : current value (registered).
//   count_next : value the counter takes if inc is applied this cycle.
//   carry      : combinational; high when inc wraps MODULUS-1 back to 00.
module bcd_mod_counter
  import time_pkg::*;
#(
  parameter int MODULUS = 60
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inc,
  input  logic                  load,
  input  logic [BCD_PAIR_W-1:0] load_val,
  output logic [BCD_PAIR_W-1:0] count,
  output logic [BCD_PAIR_W-1:0] count_next,
  output logic                  carry
);

  localparam logic [BCD_DIGIT_W-1:0] LAST_HI = 4'((MODULUS - 1) / 10);
  localparam logic [BCD_DIGIT_W-1:0] LAST_LO = 4'((MODULUS - 1) % 10);
  localparam logic [BCD_PAIR_W-1:0]  LAST    = {LAST_HI, LAST_LO};

  logic [BCD_PAIR_W-1:0] count_reg;

  always_comb begin
    count_next = count_reg;
    carry      = 1'b0;
    if (inc) begin
      if (count_reg == LAST) begin
        count_next = '0;
        carry      = 1'b1;
      end else if (count_reg[3:0] == DIGIT_MAX) begin
        count_next = {count_reg[7:4] + 4'd1, 4'd0};
      end else begin
        count_next = {count_reg[7:4], count_reg[3:0] + 4'd1};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/time_of_day_counter.sv
// HH:MM:SS time-of-day keeper in packed BCD with a 24-hour wrap.
//   sys_clk   : system clock; every flop uses its rising edge.
//   sys_rst_n : asynchronous active-low reset.
//   tod       : slave side of the time_of_day_counter_if bus.
//
// clk_1s comes from a divider on sys_clk.  Each rising edge becomes a
// one-cycle tick, one cycle after the first edge that samples it high.
// A valid set_valid loads the time and drops any tick in that same cycle.
// An invalid set or alarm write pulses set_err and changes nothing.
// alarm pulses when an increment lands on the armed alarm time.  The
// alarm stays armed afterwards, so it fires again 24 h later.
module time_of_day_counter
  import time_pkg::*;
#(
  parameter bit ALARM_EN = 1'b1
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  time_of_day_counter_if.slave tod
);

  // Edge detector.  These flops run regardless of run, so toggling run
  // can never manufacture a tick on its own.
  logic s1_reg, s2_reg, tick;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1_reg <= 1'b0;
      s2_reg <= 1'b0;
    end else begin
      s1_reg <= tod.clk_1s;
      s2_reg <= s1_reg;
    end
  end

  assign tick = s1_reg & ~s2_reg;

  logic      set_ok, set_bad, inc;
  bcd_time_t load_time;

  assign load_time = bcd_time_t'(tod.set_time);
  assign set_ok    = tod.set_valid & bcd_time_valid(load_time);
  assign set_bad   = tod.set_valid & ~bcd_time_valid(load_time);
  // A valid load wins over a coincident tick.  An invalid load does not
  // block the tick.
  assign inc       = tick & tod.run & ~set_ok;

  logic [BCD_PAIR_W-1:0] sec_cnt, min_cnt, hr_cnt;
  logic [BCD_PAIR_W-1:0] sec_next, min_next, hr_next;
  logic                  sec_carry, min_carry, hr_carry;

  bcd_mod_counter #(.MODULUS(60)) u_sec (
    .clk        (sys_clk),
    .rst_n      (sys_rst_n),
    .inc        (inc),
    .load       (set_ok),
    .load_val   (load_time.ss),
    .count      (sec_cnt),
    .count_next (sec_next),
    .carry      (sec_carry)
  );

  bcd_mod_counter #(.MODULUS(60)) u_min (
    .clk        (sys_clk),
    .rst_n      (sys_rst_n),
    .inc        (sec_carry),
    .load       (set_ok),
    .load_val   (load_time.mm),
    .count      (min_cnt),
    .count_next (min_next),
    .carry      (min_carry)
  );

  bcd_mod_counter #(.MODULUS(24)) u_hr (
    .clk        (sys_clk),
    .rst_n      (sys_rst_n),
    .inc        (min_carry),
    .load       (set_ok),
    .load_val   (load_time.hh),
    .count      (hr_cnt),
    .count_next (hr_next),
    .carry      (hr_carry)
  );

  // Post-increment time: the value time_bcd takes at this edge.
  bcd_time_t inc_time;
  assign inc_time = {hr_next, min_next, sec_next};

  logic alarm_bad, alarm_pulse;

  generate
    if (ALARM_EN) begin : g_alarm
      logic [TIME_W-1:0] alarm_time_reg;
      logic              armed_reg;
      logic              alarm_reg;
      logic              wr_ok;

      assign wr_ok     = tod.alarm_wr & bcd_time_valid(bcd_time_t'(tod.alarm_time));
      assign alarm_bad = tod.alarm_wr & ~bcd_time_valid(bcd_time_t'(tod.alarm_time));

      // The compare reads the alarm register before any write in this
      // cycle lands, so a coincident alarm_wr uses the old alarm time.
      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
          alarm_time_reg <= '0;
          armed_reg      <= 1'b0;
          alarm_reg      <= 1'b0;
        end else begin
          alarm_reg <= inc & armed_reg & (inc_time == alarm_time_reg);
          if (wr_ok) begin
            alarm_time_reg <= tod.alarm_time;
            armed_reg      <= 1'b1;
          end
        end
      end

      assign alarm_pulse = alarm_reg;
    end else begin : g_no_alarm
      assign alarm_bad   = 1'b0;
      assign alarm_pulse = 1'b0;
    end
  endgenerate

  logic sec_tick_reg, day_wrap_reg, set_err_reg;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sec_tick_reg <= 1'b0;
      day_wrap_reg <= 1'b0;
      set_err_reg  <= 1'b0;
    end else begin
      sec_tick_reg <= inc;
      day_wrap_reg <= hr_carry;
      set_err_reg  <= set_bad | alarm_bad;
    end
  end

  assign tod.time_bcd = {hr_cnt, min_cnt, sec_cnt};
  assign tod.sec_tick = sec_tick_reg;
  assign tod.day_wrap = day_wrap_reg;
  assign tod.alarm    = alarm_pulse;
  assign tod.set_err  = set_err_reg;

endmodule

// File: tb/tb_time_of_day_counter.sv
module tb_time_of_day_counter;
  import time_pkg::*;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;

  time_of_day_counter_if tod ();

  time_of_day_counter #(.ALARM_EN(1'b1)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .tod       (tod)
  );

  always #10 sys_clk = ~sys_clk;

  int checks = 0;
  int passed = 0;

  // Reference model: the time is held as seconds since midnight.
  int   m_secs, m_alarm;
  bit   m_armed, m_pend, m_prev;
  logic [23:0] e_time;
  bit   e_tick, e_wrap, e_alarm, e_err;
  bit   run_v;
  int   tick_count, wrap_count, alarm_count;

  function automatic logic [23:0] to_bcd(input int s);
    int h, m, x;
    h = s / 3600; m = (s / 60) % 60; x = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  function automatic int digit(input logic [23:0] t, input int i);
    return int'((t >> (4 * i)) & 24'hF);
  endfunction

  function automatic int to_secs(input logic [23:0] t);
    return (digit(t, 5) * 10 + digit(t, 4)) * 3600 +
           (digit(t, 3) * 10 + digit(t, 2)) * 60 + digit(t, 1) * 10 + digit(t, 0);
  endfunction

  function automatic bit valid_ref(input logic [23:0] t);
    for (int i = 0; i < 6; i++) if (digit(t, i) > 9) return 1'b0;
    return (digit(t, 5) * 10 + digit(t, 4) < 24) &&
           (digit(t, 3) * 10 + digit(t, 2) < 60) &&
           (digit(t, 1) * 10 + digit(t, 0) < 60);
  endfunction

  function automatic logic [23:0] rand_time();
    case ($urandom_range(0, 3))
      0:       return to_bcd(int'($urandom_range(0, 86399)));
      1:       return to_bcd(int'($urandom_range(86395, 86399)));
      2:       return 24'($urandom);
      default: return {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9)),
                       4'($urandom_range(0, 6)), 4'($urandom_range(0, 9)),
                       4'($urandom_range(0, 6)), 4'($urandom_range(0, 9))};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_secs = 0; m_alarm = 0; m_armed = 0; m_pend = 0; m_prev = 0;
    e_time = 24'h0; e_tick = 0; e_wrap = 0; e_alarm = 0; e_err = 0;
  endtask

  // One clock of behaviour: a rise seen at the previous edge is handled now.
  task automatic model_step(input bit v, input bit run, input bit sv, input logic [23:0] st,
                            input bit aw, input logic [23:0] at);
    bit ok_set, ok_al;
    ok_set = sv && valid_ref(st);
    ok_al  = aw && valid_ref(at);
    e_tick = 0; e_wrap = 0; e_alarm = 0;
    e_err  = (sv && !ok_set) || (aw && !ok_al);
    if (ok_set) begin
      m_secs = to_secs(st);
    end else if (m_pend && run) begin
      m_secs  = (m_secs + 1) % 86400;
      e_tick  = 1;
      e_wrap  = (m_secs == 0);
      e_alarm = m_armed && (m_secs == m_alarm);
    end
    if (ok_al) begin
      m_alarm = to_secs(at);
      m_armed = 1;
    end
    e_time = to_bcd(m_secs);
    m_pend = v && !m_prev;
    m_prev = v;
  endtask

  // Drive at the falling edge, check 1 time unit after the rising edge.
  task automatic step(input bit v, input bit sv = 0, input logic [23:0] st = 24'h0,
                      input bit aw = 0, input logic [23:0] at = 24'h0);
    tod.clk_1s = v; tod.run = run_v; tod.set_valid = sv; tod.set_time = st;
    tod.alarm_wr = aw; tod.alarm_time = at;
    model_step(v, run_v, sv, st, aw, at);
    @(posedge sys_clk);
    #1;
    check("time_bcd", tod.time_bcd, e_time);
    check("sec_tick", tod.sec_tick, e_tick);
    check("day_wrap", tod.day_wrap, e_wrap);
    check("alarm",    tod.alarm,    e_alarm);
    check("set_err",  tod.set_err,  e_err);
    tick_count  += int'(tod.sec_tick);
    wrap_count  += int'(tod.day_wrap);
    alarm_count += int'(tod.alarm);
    @(negedge sys_clk);
  endtask

  task automatic rise();
    repeat (3) step(1'b1);
    repeat (3) step(1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_time"},  tod.time_bcd, 24'h000000);
    check({tag, "_tick"},  tod.sec_tick, 1'b0);
    check({tag, "_wrap"},  tod.day_wrap, 1'b0);
    check({tag, "_alarm"}, tod.alarm,    1'b0);
    check({tag, "_err"},   tod.set_err,  1'b0);
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    tod.clk_1s = 0; tod.run = 0; tod.set_valid = 0; tod.set_time = 0;
    tod.alarm_wr = 0; tod.alarm_time = 0;
    model_reset();
    repeat (2) @(negedge sys_clk);
    check_reset_outputs("reset");
    sys_rst_n = 1'b1;
  endtask

  typedef struct {
    logic [23:0] set_time;
    bit          exp_err;
    logic [23:0] exp_time;
  } load_vec_t;

  load_vec_t vecs [12];

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, w0, a0;
    int hp;
    bit v, sv, aw;
    logic [23:0] st, at;

    vecs[0]  = '{24'h123456, 1'b0, 24'h123456};
    vecs[1]  = '{24'h240000, 1'b1, 24'h123456};
    vecs[2]  = '{24'h235959, 1'b0, 24'h235959};
    vecs[3]  = '{24'h006000, 1'b1, 24'h235959};
    vecs[4]  = '{24'h00000A, 1'b1, 24'h235959};
    vecs[5]  = '{24'h190909, 1'b0, 24'h190909};
    vecs[6]  = '{24'h200000, 1'b0, 24'h200000};
    vecs[7]  = '{24'h235A00, 1'b1, 24'h200000};
    vecs[8]  = '{24'h000000, 1'b0, 24'h000000};
    vecs[9]  = '{24'h095959, 1'b0, 24'h095959};
    vecs[10] = '{24'h1A0000, 1'b1, 24'h095959};
    vecs[11] = '{24'h000060, 1'b1, 24'h095959};

    tick_count = 0; wrap_count = 0; alarm_count = 0;
    run_v = 1'b0;
    do_reset();

    // A: three rises, each ticking one cycle after the sampling edge.
    run_v = 1'b1;
    for (int k = 0; k < 3; k++) begin
      t0 = tick_count;
      step(1'b1);
      check("lat_edge_n", tick_count - t0, 0);
      step(1'b1);
      check("lat_edge_n1", tod.sec_tick, 1'b1);
      step(1'b1);
      repeat (3) step(1'b0);
      check("one_tick_per_rise", tick_count - t0, 1);
    end
    check("seqA_time", tod.time_bcd, 24'h000003);
    check("seqA_ticks", tick_count, 3);
    $display("seq A: time %h after 3 rises, %0d ticks", tod.time_bcd, tick_count);

    // B: midnight wrap.
    step(1'b0, 1'b1, 24'h235958);
    w0 = wrap_count;
    rise();
    check("seqB_time1", tod.time_bcd, 24'h235959);
    check("seqB_wrap1", wrap_count - w0, 0);
    rise();
    check("seqB_time2", tod.time_bcd, 24'h000000);
    check("seqB_wrap2", wrap_count - w0, 1);
    $display("seq B: wrapped to %h, day_wrap pulses %0d", tod.time_bcd, wrap_count - w0);

    // C: load coincident with a tick, then an invalid load.
    t0 = tick_count;
    step(1'b1);
    step(1'b0, 1'b1, 24'h123456);
    step(1'b0);
    step(1'b0);
    check("seqC_time", tod.time_bcd, 24'h123456);
    check("seqC_no_tick", tick_count - t0, 0);
    step(1'b0, 1'b1, 24'h240000);
    check("seqC_err", tod.set_err, 1'b1);
    check("seqC_hold", tod.time_bcd, 24'h123456);
    $display("seq C: time %h after load over tick and bad load", tod.time_bcd);

    // D: alarm fires; a bad alarm write leaves it at 07:00:00.
    step(1'b0, 1'b0, 24'h0, 1'b1, 24'h070000);
    step(1'b0, 1'b1, 24'h065959);
    a0 = alarm_count;
    rise();
    check("seqD_time", tod.time_bcd, 24'h070000);
    check("seqD_alarm", alarm_count - a0, 1);
    step(1'b0, 1'b0, 24'h0, 1'b1, 24'h6A0000);
    check("seqD_err", tod.set_err, 1'b1);
    step(1'b0, 1'b1, 24'h065959);
    rise();
    check("seqD_alarm_kept", alarm_count - a0, 2);
    $display("seq D: alarm pulses %0d", alarm_count - a0);

    // E: ticks dropped while stopped, none appear on restart.
    step(1'b0, 1'b1, 24'h101010);
    t0 = tick_count;
    run_v = 1'b0;
    rise();
    rise();
    run_v = 1'b1;
    repeat (4) step(1'b0);
    check("seqE_hold", tod.time_bcd, 24'h101010);
    check("seqE_no_tick", tick_count - t0, 0);
    rise();
    check("seqE_plus1", tod.time_bcd, 24'h101011);
    $display("seq E: time %h after stop/restart", tod.time_bcd);

    // F: reset one cycle after s1 captured a rise.
    step(1'b1);
    sys_rst_n = 1'b0;
    tod.clk_1s = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("async_rst");
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    t0 = tick_count;
    repeat (4) step(1'b0);
    check("seqF_no_tick", tick_count - t0, 0);
    check("seqF_time", tod.time_bcd, 24'h000000);
    $display("seq F: time %h after mid-tick reset", tod.time_bcd);

    // Table of loads.
    foreach (vecs[i]) begin
      step(1'b0, 1'b1, vecs[i].set_time);
      check("vec_time", tod.time_bcd, vecs[i].exp_time);
      check("vec_err", tod.set_err, vecs[i].exp_err);
      $display("vec %0d: set %h -> time %h err %0d", i, vecs[i].set_time, tod.time_bcd, tod.set_err);
    end

    // Random traffic against the model.
    hp = 0; v = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (hp == 0) begin
        v  = ~v;
        hp = int'($urandom_range(2, 5));
      end
      hp--;
      if ($urandom_range(0, 29) == 0) run_v = ($urandom_range(0, 3) != 0);
      sv = ($urandom_range(0, 49) == 0);
      st = rand_time();
      aw = ($urandom_range(0, 69) == 0);
      at = ($urandom_range(0, 1) == 1) ? to_bcd((m_secs + int'($urandom_range(1, 4))) % 86400)
                                       : rand_time();
      step(v, sv, st, aw, at);
      if (sv || aw)
        $display("rand %0d: set %0d %h alarm_wr %0d %h -> time %h err %0d",
                 c, sv, st, aw, at, tod.time_bcd, tod.set_err);
    end
    $display("random: ticks %0d wraps %0d alarms %0d", tick_count, wrap_count, alarm_count);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
